fft_calc_sequencer: RTL and testbench
=====================================

# fft_calc_sequencer

Stage/butterfly scheduler for the 256-point in-place radix-2 DIT FFT core. It runs during the CALC phase of the top-level control FSM: started by `calc_start`, it issues one butterfly operand-address pair plus twiddle address per accepted handshake, stage by stage, for all log2(N) stages. Between stages it waits for the butterfly pipeline to drain, so no read-after-write hazard crosses a stage boundary. When the last butterfly of the last stage retires, it pulses `calc_done`.

## Interface
- `N`, 256, FFT length; power of two, 4..1024.
- `LOG2N`, $clog2(N), derived; not overridden.
- `clk`  in  1  single clock domain, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `calc_start`  in  1  start pulse; sampled only in IDLE.
- `issue_valid`  out  1  current `idx1`/`idx2`/`twiddle_addr` are a valid butterfly request.
- `issue_ready`  in  1  butterfly unit accepts the request this cycle.
- `idx1`  out  LOG2N  upper-wing operand address.
- `idx2`  out  LOG2N  lower-wing operand address.
- `twiddle_addr`  out  LOG2N  twiddle ROM address; MSB always 0.
- `stage`  out  LOG2N  current stage number, 0..LOG2N-1.
- `bfly_valid`  in  1  one butterfly retired (its results were written back).
- `busy`  out  1  high in every state except IDLE.
- `calc_done`  out  1  one-cycle completion pulse.
- `seq_err`  out  1  sticky; set when `bfly_valid` arrives with nothing outstanding.

## Operation
- **Reset values:** state IDLE. `issue_valid`, `busy`, `calc_done` and `seq_err` are 0. `stage`, `idx1`, `idx2` and `twiddle_addr` are 0.
- **Registered state:**
  - state
  - butterfly counter `k`, LOG2N-1 bits, range 0..N/2-1
  - `stage`
  - outstanding counter `out_cnt`, LOG2N bits, range 0..N/2
  - `seq_err`
- **Address outputs:** decoded combinationally from registered `k` and `stage` only. There is no combinational path from any input to any output.
  - `half = 1 << stage`
  - `pos = k & (half-1)`
  - `grp = k >> stage`
  - `idx1 = (grp << (stage+1)) | pos`
  - `idx2 = idx1 + half`
  - `twiddle_addr = pos << (LOG2N-1-stage)`
- **State machine:**
  - **IDLE:** on `calc_start`, clear `k`, `stage` and `out_cnt`, then go to ISSUE. `seq_err` is not cleared.
  - **ISSUE:** `issue_valid` = 1. On `issue_valid && issue_ready`, `k` increments. If `k == N/2-1` at that handshake, `k` wraps to 0 and the next state is DRAIN.
  - **DRAIN:** `issue_valid` = 0. When `out_cnt == 0`: if `stage == LOG2N-1`, go to DONE; otherwise increment `stage` and go to ISSUE.
  - **DONE:** `calc_done` = 1 for this one cycle, then go to IDLE.
- **out_cnt update:**
  - +1 on a handshake.
  - -1 on `bfly_valid`.
  - Both in the same cycle: unchanged.
  - `bfly_valid` with `out_cnt == 0` and no same-cycle handshake: ignored, `out_cnt` stays 0, `seq_err` is set.
- **Handshake rules:**
  - While `issue_valid` = 1 and `issue_ready` = 0, the address outputs hold stable.
  - `issue_valid` never drops in ISSUE without a handshake.
- **Ignored events:**
  - `calc_start` outside IDLE, including a start on the DONE cycle.
  - `bfly_valid` in IDLE. This still sets `seq_err`, since `out_cnt` = 0.
- **Reset mid-operation:** immediate return to reset values. Any in-flight butterflies are abandoned.

## Timing
- `calc_start` high at cycle t in IDLE: `busy` and `issue_valid` are high at t+1, presenting stage 0, k = 0 (`idx1`=0, `idx2`=1, `tw`=0).
- With `issue_ready` tied to 1:
  - One issue per cycle, N/2 cycles per stage.
  - DRAIN is entered the cycle after the last issue of a stage.
  - The next stage's first issue comes one cycle after the DRAIN cycle in which `out_cnt` is seen as 0.
- With butterfly retire latency L (handshake at c, `bfly_valid` at c+L):
  - Each stage takes N/2 + L + 1 cycles.
  - `calc_done` arrives at t + 1 + LOG2N·(N/2+L+1).
  - For N = 256 and L = 3: t + 1057.
- `busy` falls the cycle after the `calc_done` pulse.

## Structure
- **Shared package `fft_pkg`:**
  - the `seq_state_t` enum (IDLE, ISSUE, DRAIN, DONE)
  - `FFT_N` = 256 and `FFT_LOG2N` = 8, also used by the top level, the twiddle ROM and the buffer controllers
- **Sub-module:** one natural sub-module, `fft_bfly_addr_gen`, a purely combinational (`k`, `stage`) → (`idx1`, `idx2`, `twiddle_addr`) decoder. It is reusable by the verification model.

## Test plan
- **Full run, N = 256, ready = 1, retire L = 3:** stage 0 addresses pairs (0,1),(2,3)…(254,255) with tw = 0. Stage 7 addresses (k, k+128) with tw = k. `calc_done` is a single pulse at t + 1057. `seq_err` = 0.
- **Backpressure, N = 8:** random `issue_ready` (50%). Each (`idx1`, `idx2`, `tw`) is held stable until accepted. The accepted sequence equals the ready = 1 sequence, e.g. stage 1 is (0,2,0),(1,3,2),(4,6,0),(5,7,2).
- **Drain hazard:** hold `bfly_valid` off for 20 cycles after stage 0 issue completes. `issue_valid` stays 0 and `stage` stays 0 until 4 retires arrive (N = 8). Stage 1 issue starts exactly one cycle after `out_cnt` reaches 0.
- **Simultaneous issue/retire:** handshake and `bfly_valid` in the same cycle leave `out_cnt` unchanged. `bfly_valid` in IDLE sets `seq_err`, which stays set through a following run.
- **Start while busy:** `calc_start` pulses at stage 2 and on the DONE cycle. Both are ignored: exactly one `calc_done` and no restart.
- **Reset mid-run:** assert `rst_n` = 0 during stage 3. All outputs return to 0 asynchronously. A fresh `calc_start` then runs a full sequence from stage 0, k = 0.

Source files
------------

// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_pkg
//  Description : Shared FFT constants and the calc-sequencer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int FFT_N     = 256;
    localparam int FFT_LOG2N = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

endpackage : fft_pkg
`default_nettype wire

// File: rtl/fft_bfly_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : fft_bfly_addr_gen
//  Description : Combinational (k, stage) -> (idx1, idx2, twiddle) decoder for
//                an in-place radix-2 DIT FFT.
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_bfly_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2N = FFT_LOG2N
) (
    input  logic [LOG2N-2:0] k_i,
    input  logic [LOG2N-1:0] stage_i,
    output logic [LOG2N-1:0] idx1_o,
    output logic [LOG2N-1:0] idx2_o,
    output logic [LOG2N-1:0] tw_o
);

    localparam logic [LOG2N-1:0] ONE       = LOG2N'(1);
    localparam logic [LOG2N-1:0] MAX_STAGE = LOG2N'(LOG2N - 1);

    logic [LOG2N-1:0] k_ext;
    logic [LOG2N-1:0] half;
    logic [LOG2N-1:0] mask;
    logic [LOG2N-1:0] pos;

    // Group bits of k move up one place to open the wing gap; the low
    // (in-group) bits stay put and also select the twiddle step.
    always_comb begin
        k_ext  = {1'b0, k_i};
        half   = ONE << stage_i;
        mask   = half - ONE;
        pos    = k_ext & mask;
        idx1_o = ((k_ext & ~mask) << 1) | pos;
        idx2_o = idx1_o + half;
        tw_o   = pos << (MAX_STAGE - stage_i);
    end

endmodule : fft_bfly_addr_gen
`default_nettype wire

// File: rtl/fft_calc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fft_calc_sequencer
//  Description : Stage/butterfly scheduler for the in-place radix-2 DIT FFT.
//                Issues one butterfly per handshake, drains the butterfly
//                pipeline between stages, pulses calc_done at the end.
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_calc_sequencer
    import fft_pkg::*;
#(
    parameter  int N     = FFT_N,
    localparam int LOG2N = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             calc_start_i,
    output logic             issue_valid_o,
    input  logic             issue_ready_i,
    output logic [LOG2N-1:0] idx1_o,
    output logic [LOG2N-1:0] idx2_o,
    output logic [LOG2N-1:0] twiddle_addr_o,
    output logic [LOG2N-1:0] stage_o,
    input  logic             bfly_valid_i,
    output logic             busy_o,
    output logic             calc_done_o,
    output logic             seq_err_o
);

    localparam logic [LOG2N-2:0] K_LAST     = '1;
    localparam logic [LOG2N-1:0] STAGE_LAST = LOG2N'(LOG2N - 1);

    seq_state_t       state_q, state_d;
    logic [LOG2N-2:0] k_q, k_d;
    logic [LOG2N-1:0] stage_q, stage_d;
    logic [LOG2N-1:0] out_cnt_q, out_cnt_d;
    logic             seq_err_q, seq_err_d;

    logic             handshake;
    logic [LOG2N-1:0] gen_idx1;
    logic [LOG2N-1:0] gen_idx2;
    logic [LOG2N-1:0] gen_tw;

    assign handshake = (state_q == ISSUE) && issue_ready_i;

    fft_bfly_addr_gen #(
        .LOG2N (LOG2N)
    ) u_addr_gen (
        .k_i     (k_q),
        .stage_i (stage_q),
        .idx1_o  (gen_idx1),
        .idx2_o  (gen_idx2),
        .tw_o    (gen_tw)
    );

    // State and datapath registers; reset abandons any in-flight work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            k_q       <= '0;
            stage_q   <= '0;
            out_cnt_q <= '0;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            stage_q   <= stage_d;
            out_cnt_q <= out_cnt_d;
            seq_err_q <= seq_err_d;
        end
    end

    // Next-state: outstanding tracking first, then FSM transitions which may
    // override the counters (a start clears them).
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        stage_d   = stage_q;
        out_cnt_d = out_cnt_q;
        seq_err_d = seq_err_q;

        if (handshake && !bfly_valid_i) begin
            out_cnt_d = out_cnt_q + LOG2N'(1);
        end else if (!handshake && bfly_valid_i) begin
            // A retire with nothing outstanding is a protocol error; the
            // counter must not underflow.
            if (out_cnt_q == '0) begin
                seq_err_d = 1'b1;
            end else begin
                out_cnt_d = out_cnt_q - LOG2N'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (calc_start_i) begin
                    k_d       = '0;
                    stage_d   = '0;
                    out_cnt_d = '0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (handshake) begin
                    if (k_q == K_LAST) begin
                        k_d     = '0;
                        state_d = DRAIN;
                    end else begin
                        k_d = k_q + (LOG2N-1)'(1);
                    end
                end
            end
            DRAIN: begin
                // Next stage reads results of this one, so wait for all
                // retires before issuing again.
                if (out_cnt_q == '0) begin
                    if (stage_q == STAGE_LAST) begin
                        state_d = DONE;
                    end else begin
                        stage_d = stage_q + LOG2N'(1);
                        state_d = ISSUE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs depend on registered state only; addresses read as zero
    // whenever no request is being presented.
    always_comb begin
        issue_valid_o  = (state_q == ISSUE);
        busy_o         = (state_q != IDLE);
        calc_done_o    = (state_q == DONE);
        seq_err_o      = seq_err_q;
        stage_o        = stage_q;
        idx1_o         = issue_valid_o ? gen_idx1 : '0;
        idx2_o         = issue_valid_o ? gen_idx2 : '0;
        twiddle_addr_o = issue_valid_o ? gen_tw   : '0;
    end

endmodule : fft_calc_sequencer
`default_nettype wire

// File: tb/tb_fft_calc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_calc_sequencer
//  Description : Directed self-checking bench; one N=256 and one N=8 instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_calc_sequencer;

    localparam int BN = 256;
    localparam int SN = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // N = 256 instance
    logic       b_start = 1'b0, b_ready = 1'b0, b_bv = 1'b0;
    logic       b_valid, b_busy, b_done, b_err;
    logic [7:0] b_idx1, b_idx2, b_tw, b_stage;
    // N = 8 instance
    logic       s_start = 1'b0, s_ready = 1'b0, s_bv = 1'b0;
    logic       s_valid, s_busy, s_done, s_err;
    logic [2:0] s_idx1, s_idx2, s_tw, s_stage;

    int total = 0;
    int bad   = 0;

    logic [2:0] b_pipe = '0;   // retire line for the big instance, L = 3
    int  s_pend = 0;           // outstanding count for the small instance
    bit  s_auto = 1'b0;
    bit  s_hold = 1'b0;

    always #5 clk = ~clk;

    fft_calc_sequencer #(.N(BN)) u_big (
        .clk(clk), .rst_n(rst_n), .calc_start_i(b_start),
        .issue_valid_o(b_valid), .issue_ready_i(b_ready),
        .idx1_o(b_idx1), .idx2_o(b_idx2), .twiddle_addr_o(b_tw),
        .stage_o(b_stage), .bfly_valid_i(b_bv), .busy_o(b_busy),
        .calc_done_o(b_done), .seq_err_o(b_err)
    );

    fft_calc_sequencer #(.N(SN)) u_small (
        .clk(clk), .rst_n(rst_n), .calc_start_i(s_start),
        .issue_valid_o(s_valid), .issue_ready_i(s_ready),
        .idx1_o(s_idx1), .idx2_o(s_idx2), .twiddle_addr_o(s_tw),
        .stage_o(s_stage), .bfly_valid_i(s_bv), .busy_o(s_busy),
        .calc_done_o(s_done), .seq_err_o(s_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Textbook DIT enumeration: groups of 2*half, pos within group.
    function automatic void exp_addr(input int n, input int s, input int k,
                                     output int e1, output int e2, output int et);
        int half, grp, pos;
        half = 1 << s;
        grp  = k / half;
        pos  = k % half;
        e1   = grp * 2 * half + pos;
        e2   = e1 + half;
        et   = pos * (n / (2 * half));
    endfunction

    // One clock: drive retire inputs, advance, sample at edge + 1.
    task automatic tick();
        logic b_hs, s_hs;
        b_bv = b_pipe[2];
        if (s_auto) s_bv = !s_hold && (s_pend > 0);
        b_hs = b_valid && b_ready;
        s_hs = s_valid && s_ready;
        @(posedge clk);
        #1;
        b_pipe = {b_pipe[1:0], b_hs};
        if (s_auto) s_pend = s_pend + int'(s_hs) - int'(s_bv);
    endtask

    // Full N = 256 run with ready = 1 and L = 3, checked against the model.
    task automatic run_big(input string tag);
        int cyc, es, ek, nacc, e1, e2, et;
        logic [31:0] ev;
        es = 0; ek = 0; nacc = 0;
        b_ready = 1'b1;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        cyc = 1;
        chk({tag, "_first_ctl"}, {b_busy, b_valid}, 32'h3);
        chk({tag, "_first_addr"}, {b_stage, b_idx1, b_idx2, b_tw}, 32'h0000_0100);
        while (!b_done && cyc < 1500) begin
            if (b_valid && b_ready) begin
                exp_addr(BN, es, ek, e1, e2, et);
                ev = {es[7:0], e1[7:0], e2[7:0], et[7:0]};
                chk($sformatf("%s_s%0d_k%0d", tag, es, ek), {b_stage, b_idx1, b_idx2, b_tw}, ev);
                nacc++;
                ek++;
                if (ek == BN / 2) begin ek = 0; es++; end
            end
            tick();
            cyc++;
        end
        chk({tag, "_done_cycle"}, cyc, 1057);
        chk({tag, "_issue_count"}, nacc, 1024);
        chk({tag, "_seq_err"}, {31'd0, b_err}, 32'd0);
        tick();
        chk({tag, "_after_done"}, {b_done, b_busy}, 32'd0);
    endtask

    initial begin
        int cyc, es, ek, nacc, e1, e2, et, ndone, dcyc;
        bit have_hold, pulsed;
        logic [31:0] held, ev;

        // ---------------- reset state
        tick();
        tick();
        chk("rst_big_ctl", {b_valid, b_busy, b_done, b_err}, 32'd0);
        chk("rst_big_addr", {b_stage, b_idx1, b_idx2, b_tw}, 32'd0);
        chk("rst_small_ctl", {s_valid, s_busy, s_done, s_err}, 32'd0);
        chk("rst_small_addr", {s_stage, s_idx1, s_idx2, s_tw}, 32'd0);
        rst_n = 1'b1;
        tick();

        // ---------------- full run N = 256
        run_big("full");

        // ---------------- backpressure N = 8
        s_auto = 1'b1; s_hold = 1'b0; s_pend = 0;
        s_ready = 1'b0;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        cyc = 1; es = 0; ek = 0; nacc = 0; have_hold = 1'b0; held = '0;
        while (!s_done && cyc < 400) begin
            s_ready = 1'($urandom_range(0, 1));
            if (have_hold)
                chk("bp_hold", {s_valid, s_stage, s_idx1, s_idx2, s_tw}, held);
            if (s_valid && s_ready) begin
                exp_addr(SN, es, ek, e1, e2, et);
                ev = {20'd0, es[2:0], e1[2:0], e2[2:0], et[2:0]};
                chk($sformatf("bp_s%0d_k%0d", es, ek), {s_stage, s_idx1, s_idx2, s_tw}, ev);
                nacc++;
                ek++;
                if (ek == SN / 2) begin ek = 0; es++; end
            end
            have_hold = s_valid && !s_ready;
            held = {19'd0, s_valid, s_stage, s_idx1, s_idx2, s_tw};
            tick();
            cyc++;
        end
        chk("bp_done_seen", {31'd0, s_done}, 32'd1);
        chk("bp_issue_count", nacc, 12);
        s_ready = 1'b0;
        tick();
        chk("bp_after", {s_busy, s_err}, 32'd0);

        // ---------------- drain hazard N = 8
        s_hold = 1'b1; s_pend = 0; s_ready = 1'b1;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 20; i++) begin
            chk("hz_wait", {s_valid, s_stage}, 32'd0);
            tick();
        end
        s_hold = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("hz_drain", {s_valid, s_busy}, 32'h1);
            tick();
        end
        chk("hz_stage1_first", {s_valid, s_stage, s_idx1, s_idx2, s_tw}, 32'b1_001_000_010_000);
        cyc = 0;
        while (!s_done && cyc < 100) begin tick(); cyc++; end
        chk("hz_done_seen", {31'd0, s_done}, 32'd1);
        tick();
        chk("hz_after", {s_busy, s_err}, 32'd0);

        // ---------------- bfly_valid in IDLE, then a run with overlap
        s_auto = 1'b0;
        s_bv = 1'b1;
        tick();
        s_bv = 1'b0;
        chk("idle_bv_err", {s_busy, s_err}, 32'h1);
        s_auto = 1'b1; s_pend = 0; s_ready = 1'b1;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        cyc = 1;
        while (!s_done && cyc < 100) begin tick(); cyc++; end
        chk("overlap_done_cycle", cyc, 19);
        chk("overlap_err_sticky", {31'd0, s_err}, 32'd1);
        tick();

        // ---------------- start while busy / on DONE
        s_pend = 0;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        ndone = 0; dcyc = 0; pulsed = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (s_done) begin
                ndone++; dcyc = c; s_start = 1'b1;
            end else if (s_stage == 3'd2 && s_valid && !pulsed) begin
                s_start = 1'b1; pulsed = 1'b1;
            end else begin
                s_start = 1'b0;
            end
            tick();
        end
        s_start = 1'b0;
        chk("sb_stage2_reached", {31'd0, pulsed}, 32'd1);
        chk("sb_done_count", ndone, 1);
        chk("sb_done_cycle", dcyc, 19);
        chk("sb_idle_after", {s_busy, s_valid}, 32'd0);

        // ---------------- reset mid-run (big, stage 3)
        b_ready = 1'b1;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        cyc = 0;
        while (b_stage != 8'd3 && cyc < 2000) begin tick(); cyc++; end
        chk("mr_reached_stage3", {b_stage, 7'd0, b_valid}, 32'h301);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_big_ctl", {b_valid, b_busy, b_done, b_err}, 32'd0);
        chk("mr_big_addr", {b_stage, b_idx1, b_idx2, b_tw}, 32'd0);
        chk("mr_small_err", {31'd0, s_err}, 32'd0);
        b_pipe = '0; b_bv = 1'b0; s_pend = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        run_big("rerun");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fft_calc_sequencer
`default_nettype wire
